// File: rtl/aes_pkg.sv
// aes_pkg: shared AES definitions for the key schedule and the cipher datapath.
//   key_len_e  : key-length encoding used on key_len ports
//   ks_state_e : key-schedule sequencer states
//   nk_of/nr_of: key words / round count for a key_len code (0 for the illegal code)
//   sbox       : forward S-box byte substitution (also used by cipher SubBytes)
//   xtime      : multiply by x in GF(2^8), used to advance rcon
package aes_pkg;

  typedef enum logic [1:0] {
    KL_128     = 2'd0,
    KL_192     = 2'd1,
    KL_256     = 2'd2,
    KL_ILLEGAL = 2'd3
  } key_len_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_EXPAND,
    S_FIN
  } ks_state_e;

  function automatic logic [3:0] nk_of(input logic [1:0] kl);
    case (kl)
      KL_128:  return 4'd4;
      KL_192:  return 4'd6;
      KL_256:  return 4'd8;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] kl);
    case (kl)
      KL_128:  return 4'd10;
      KL_192:  return 4'd12;
      KL_256:  return 4'd14;
      default: return 4'd0;
    endcase
  endfunction

  // Row-major table, entry b at bits [8*b +: 8] counting from the left.
  localparam logic [0:2047] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[{b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_subword.sv
// aes_subword: combinational SubWord, one S-box lane per byte.
//   din  : 32-bit input word
//   dout : S-box applied to each byte of din
module aes_subword
  import aes_pkg::*;
(
  input  logic [31:0] din,
  output logic [31:0] dout
);

  always_comb begin
    dout = {sbox(din[31:24]), sbox(din[23:16]), sbox(din[15:8]), sbox(din[7:0])};
  end

endmodule

// File: rtl/key_expansion_seq.sv
// key_expansion_seq: iterative AES-128/192/256 key schedule, one word per clock,
// schedule kept in a word array and read back one round key per request.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : begin a run (sampled in IDLE only), latches key and key_len
//   key_len    : 0=AES-128, 1=AES-192, 2=AES-256, 3=illegal
//   key        : cipher key, bit 0 = MSB, first Nk words used
//   busy       : LOAD/EXPAND in progress
//   done       : one-cycle end-of-run pulse; err accompanies it on a bad key_len
//   key_ready  : schedule complete and readable
//   rk_idx     : round key index, rk_out/rk_valid follow one cycle later
module key_expansion_seq
  import aes_pkg::*;
#(
  parameter int unsigned MAX_NK   = 8,
  parameter int unsigned RK_IDX_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [1:0]           key_len,
  input  logic [0:32*MAX_NK-1] key,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 key_ready,
  input  logic [RK_IDX_W-1:0]  rk_idx,
  output logic [127:0]         rk_out,
  output logic                 rk_valid
);

  localparam int unsigned DEPTH = 4 * (MAX_NK + 7);
  localparam int unsigned IW    = $clog2(DEPTH);

  ks_state_e state, nxt;

  logic [32*MAX_NK-1:0] key_q;
  logic [1:0]           kl_q;
  logic [IW-1:0]        i_q;
  logic [3:0]           cnt_q;
  logic [7:0]           rcon_q;
  logic                 err_q, kr_q, rkv_q;
  logic [127:0]         rk_q;
  logic [31:0]          w [DEPTH];

  logic [3:0]    nk, nr;
  logic [IW-1:0] nk_w, last_i, prev_idx, back_idx, rbase;
  logic          legal, accept, rd_ok;
  logic [31:0]   prev, sub_in, sub_out, temp, new_w;

  always_comb begin
    nk       = nk_of(kl_q);
    nr       = nr_of(kl_q);
    nk_w     = IW'(nk);
    last_i   = IW'(4 * (32'(nr) + 1) - 1);
    legal    = (key_len != KL_ILLEGAL) && (32'(nk_of(key_len)) <= MAX_NK);
    accept   = (state == S_IDLE) && start;
    // Indices are clamped outside EXPAND so no read ever wraps below zero.
    prev_idx = (i_q == '0) ? '0 : i_q - 1'b1;
    back_idx = (state == S_EXPAND) ? i_q - nk_w : '0;
    prev     = w[prev_idx];
    sub_in   = (cnt_q == '0) ? {prev[23:0], prev[31:24]} : prev;
    rd_ok    = kr_q && (32'(rk_idx) <= 32'(nr));
    rbase    = rd_ok ? IW'(32'(rk_idx) * 4) : '0;
  end

  aes_subword u_subword (
    .din  (sub_in),
    .dout (sub_out)
  );

  always_comb begin
    if (cnt_q == '0) begin
      temp = sub_out ^ {rcon_q, 24'h0};
    end else if (nk == 4'd8 && cnt_q == 4'd4) begin
      temp = sub_out;
    end else begin
      temp = prev;
    end
    new_w = w[back_idx] ^ temp;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:   if (start) nxt = legal ? S_LOAD : S_FIN;
      S_LOAD:   nxt = S_EXPAND;
      S_EXPAND: if (i_q == last_i) nxt = S_FIN;
      S_FIN:    nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
    busy      = (state == S_LOAD) || (state == S_EXPAND);
    done      = (state == S_FIN);
    err       = err_q;
    key_ready = kr_q;
    rk_out    = rk_q;
    rk_valid  = rkv_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kl_q   <= '0;
      i_q    <= '0;
      cnt_q  <= '0;
      rcon_q <= 8'h01;
      err_q  <= 1'b0;
      kr_q   <= 1'b0;
      rk_q   <= '0;
      rkv_q  <= 1'b0;
    end else begin
      if (accept) begin
        kl_q  <= key_len;
        err_q <= !legal;
        kr_q  <= 1'b0;
      end
      if (state == S_LOAD) begin
        i_q    <= nk_w;
        cnt_q  <= '0;
        rcon_q <= 8'h01;
      end
      if (state == S_EXPAND) begin
        i_q   <= i_q + 1'b1;
        // cnt_q tracks i mod Nk without a divider.
        cnt_q <= (cnt_q == nk - 4'd1) ? '0 : cnt_q + 4'd1;
        if (cnt_q == '0) rcon_q <= xtime(rcon_q);
        if (i_q == last_i) kr_q <= 1'b1;
      end
      rkv_q <= rd_ok;
      rk_q  <= rd_ok ? {w[rbase], w[rbase + IW'(1)], w[rbase + IW'(2)], w[rbase + IW'(3)]} : '0;
    end
  end

  // Key latch and word array carry no reset; key_ready guards their contents.
  always_ff @(posedge clk) begin
    if (accept) key_q <= key;
    if (state == S_LOAD) begin
      for (int unsigned j = 0; j < MAX_NK; j++) begin
        if (j < 32'(nk)) w[IW'(j)] <= key_q[32*(MAX_NK-j)-1 -: 32];
      end
    end
    if (state == S_EXPAND) w[i_q] <= new_w;
  end

endmodule

// File: tb/tb_key_expansion_seq.sv
module tb_key_expansion_seq;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   key_len = 2'd0;
  logic [0:255] key = '0;
  logic [3:0]   rk_idx = 4'd0;
  logic         busy, done, err, key_ready, rk_valid;
  logic [127:0] rk_out;

  always #5 clk = ~clk;

  key_expansion_seq #(.MAX_NK(8), .RK_IDX_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .key_len   (key_len),
    .key       (key),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .key_ready (key_ready),
    .rk_idx    (rk_idx),
    .rk_out    (rk_out),
    .rk_valid  (rk_valid)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  logic [7:0]  sb [256];
  logic [31:0] pend [60];
  logic [31:0] sched [60];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = '0; x = a; y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]};
      sb[x] = s ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] v);
    return {sb[v[31:24]], sb[v[23:16]], sb[v[15:8]], sb[v[7:0]]};
  endfunction

  task automatic build_sched(input logic [255:0] kp, input int nk);
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < nk; i++) pend[i] = kp[255-32*i -: 32];
    rc = 8'h01;
    for (int i = nk; i < 4 * (nk + 7); i++) begin
      t = pend[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      pend[i] = pend[i-nk] ^ t;
    end
  endtask

  function automatic logic [127:0] mrk(input int r);
    return {pend[4*r], pend[4*r+1], pend[4*r+2], pend[4*r+3]};
  endfunction

  // Reference timeline: a run occupies 1 + (4*(Nr+1) - Nk) busy cycles.
  int           m_left, m_nr;
  logic         m_done, m_err, m_kr, m_rkv;
  logic [127:0] m_rk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0; m_nr <= 10; m_done <= 1'b0; m_err <= 1'b0;
      m_kr <= 1'b0; m_rkv <= 1'b0; m_rk <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_left == 0 && !m_done && start) begin
        m_err <= (key_len == 2'd3);
        m_kr  <= 1'b0;
        if (key_len == 2'd3) begin
          m_done <= 1'b1;
        end else begin
          m_left <= 4 * (11 + 2 * int'(key_len)) - (4 + 2 * int'(key_len)) + 1;
          m_nr   <= 10 + 2 * int'(key_len);
          sched  <= pend;
        end
      end else if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_done <= 1'b1;
          m_kr   <= 1'b1;
        end
      end
      if (m_kr && int'(rk_idx) <= m_nr) begin
        m_rkv <= 1'b1;
        m_rk  <= {sched[4*rk_idx], sched[4*rk_idx+1], sched[4*rk_idx+2], sched[4*rk_idx+3]};
      end else begin
        m_rkv <= 1'b0;
        m_rk  <= '0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      chk("busy", busy, m_left != 0);
      chk("done", done, m_done);
      chk("err", err, m_err);
      chk("key_ready", key_ready, m_kr);
      chk("rk_valid", rk_valid, m_rkv);
      chk("rk_out", rk_out, m_rk);
    end
  end

  task automatic run_case(input string nm, input logic [1:0] kl, input logic [255:0] kp,
                          input int nk, input int exp_cyc, input bit pulse, input int abort_at);
    int cyc;
    if (kl != 2'd3) build_sched(kp, nk);
    key = kp; key_len = kl; start = 1'b1;
    cyc = 0;
    for (int c = 1; c <= 100 && cyc == 0; c++) begin
      @(negedge clk);
      start = pulse && (c == 5 || c == 20);
      if (abort_at != 0 && c == abort_at) begin
        #2 rst_n = 1'b0;
        #1;
        chk({nm, "_abort_busy"}, busy, 0);
        chk({nm, "_abort_key_ready"}, key_ready, 0);
        chk({nm, "_abort_done"}, done, 0);
        chk({nm, "_abort_rk_valid"}, rk_valid, 0);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        return;
      end
      if (done) cyc = c;
    end
    start = 1'b0;
    chk({nm, "_cycles"}, cyc, exp_cyc);
  endtask

  task automatic rd(input int idx, input logic [127:0] exp, input logic expv, input string nm);
    rk_idx = 4'(idx);
    @(negedge clk);
    chk({nm, "_valid"}, rk_valid, expv);
    chk(nm, rk_out, exp);
  endtask

  logic [255:0] k128, k192, k256;
  logic [127:0] rk128_1, rk128_10, rk192_12, rk256_14;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    k128 = 256'h2b7e1516_28aed2a6_abf71588_09cf4f3c_deadbeef_deadbeef_deadbeef_deadbeef;
    k192 = 256'h8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b_cafef00d_cafef00d;
    k256 = 256'h603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4;
    rk128_1  = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
    rk128_10 = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
    rk192_12 = 128'he98ba06f_448c773c_8ecc7204_01002202;
    rk256_14 = 128'hfe4890d1_e6188d0b_046df344_706c631e;

    build_sbox();
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_key_ready", key_ready, 0);
    chk("rst_rk_out", rk_out, 0);

    run_case("aes128", 2'd0, k128, 4, 42, 1'b1, 0);
    chk("model_rk1_128", mrk(1), rk128_1);
    chk("model_rk10_128", mrk(10), rk128_10);
    rd(0, k128[255:128], 1'b1, "aes128_rk0");
    rd(1, rk128_1, 1'b1, "aes128_rk1");
    rd(10, rk128_10, 1'b1, "aes128_rk10");
    rd(11, 128'h0, 1'b0, "aes128_rk11");

    run_case("aes192", 2'd1, k192, 6, 48, 1'b1, 0);
    chk("model_rk12_192", mrk(12), rk192_12);
    rd(12, rk192_12, 1'b1, "aes192_rk12");
    rd(13, 128'h0, 1'b0, "aes192_rk13");

    run_case("aes256", 2'd2, k256, 8, 54, 1'b0, 0);
    chk("model_rk14_256", mrk(14), rk256_14);
    rd(14, rk256_14, 1'b1, "aes256_rk14");
    rd(15, 128'h0, 1'b0, "aes256_rk15");

    run_case("illegal", 2'd3, k128, 4, 1, 1'b0, 0);
    chk("illegal_err", err, 1);
    chk("illegal_key_ready", key_ready, 0);
    rd(1, 128'h0, 1'b0, "illegal_rk1");

    run_case("aes128_after_err", 2'd0, k128, 4, 42, 1'b0, 0);
    chk("after_err_err", err, 0);
    rd(10, rk128_10, 1'b1, "after_err_rk10");

    run_case("abort", 2'd2, k256, 8, 0, 1'b0, 22);
    chk("post_abort_key_ready", key_ready, 0);

    run_case("aes128_post_rst", 2'd0, k128, 4, 42, 1'b0, 0);
    rd(1, rk128_1, 1'b1, "post_rst_rk1");
    rd(10, rk128_10, 1'b1, "post_rst_rk10");
    rd(0, k128[255:128], 1'b1, "post_rst_rk0");

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
